// File: rtl/relogio_pkg.sv
// Shared types and constants for the clock time-setting path: FSM states,
// BCD field widths, display blank bit positions and field maxima.
package relogio_pkg;

    typedef enum logic [1:0] {RUN, SET_H, SET_M, SET_S} ajuste_state_t;

    localparam int unsigned H_MSD_W = 2;
    localparam int unsigned H_LSD_W = 4;
    localparam int unsigned M_MSD_W = 3;
    localparam int unsigned M_LSD_W = 4;
    localparam int unsigned S_MSD_W = 3;
    localparam int unsigned S_LSD_W = 4;

    localparam int unsigned BLANK_W     = 6;
    localparam int unsigned BLANK_H_MSD = 5;
    localparam int unsigned BLANK_H_LSD = 4;
    localparam int unsigned BLANK_M_MSD = 3;
    localparam int unsigned BLANK_M_LSD = 2;
    localparam int unsigned BLANK_S_MSD = 1;
    localparam int unsigned BLANK_S_LSD = 0;

    localparam int unsigned HOUR_MAX   = 23;
    localparam int unsigned MINSEC_MAX = 59;

    // Two-digit BCD increment that wraps to 00 once the field reaches max_val.
    function automatic logic [7:0] bcd_inc(input logic [3:0] msd,
                                           input logic [3:0] lsd,
                                           input int unsigned max_val);
        logic [7:0] r;
        int unsigned v;
        v = 32'(msd) * 10 + 32'(lsd);
        if (v >= max_val)
            r = '0;
        else if (lsd >= 4'd9)
            r = {msd + 4'd1, 4'd0};
        else
            r = {msd, lsd + 4'd1};
        return r;
    endfunction

endpackage

// File: rtl/debounce_pulse.sv
// Raw pushbutton to single accepted-press pulse: 2-flop synchronizer,
// consecutive-cycle debouncer and rising-edge detector.
module debounce_pulse #(
    parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
    input  logic clock,
    input  logic reset,
    input  logic button,
    output logic pulse
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_q;
    logic [CW-1:0] count;

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            count   <= '0;
        end else begin
            sync1   <= button;
            sync2   <= sync1;
            level_q <= level;
            // Any sample equal to the filtered level restarts the stability count.
            if (sync2 == level) begin
                count <= '0;
            end else if (count == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync2;
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

    assign pulse = level & ~level_q;

endmodule

// File: rtl/ajuste_relogio.sv
// Time-setting controller: button-driven edit FSM that freezes the clock,
// blinks the active field and issues a one-cycle load of the edited BCD time.
module ajuste_relogio
    import relogio_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500_000,
    parameter int unsigned BLINK_CYCLES    = 25_000_000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               btn_mode,
    input  logic               btn_inc,
    input  logic [H_MSD_W-1:0] cur_h_msd,
    input  logic [H_LSD_W-1:0] cur_h_lsd,
    input  logic [M_MSD_W-1:0] cur_m_msd,
    input  logic [M_LSD_W-1:0] cur_m_lsd,
    input  logic [S_MSD_W-1:0] cur_s_msd,
    input  logic [S_LSD_W-1:0] cur_s_lsd,
    output logic [H_MSD_W-1:0] set_h_msd,
    output logic [H_LSD_W-1:0] set_h_lsd,
    output logic [M_MSD_W-1:0] set_m_msd,
    output logic [M_LSD_W-1:0] set_m_lsd,
    output logic [S_MSD_W-1:0] set_s_msd,
    output logic [S_LSD_W-1:0] set_s_lsd,
    output logic               load,
    output logic               run,
    output logic [BLANK_W-1:0] blank
);

    localparam int unsigned H_W = H_MSD_W + H_LSD_W;
    localparam int unsigned M_W = M_MSD_W + M_LSD_W;
    localparam int unsigned S_W = S_MSD_W + S_LSD_W;
    localparam int unsigned BW  = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    ajuste_state_t state;
    logic          p_mode;
    logic          p_inc;
    logic [BW-1:0] blink_cnt;
    logic          phase;
    logic [H_W-1:0] h_next;
    logic [M_W-1:0] m_next;
    logic [S_W-1:0] s_next;

    debounce_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
        .clock  (clock),
        .reset  (reset),
        .button (btn_mode),
        .pulse  (p_mode)
    );

    debounce_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
        .clock  (clock),
        .reset  (reset),
        .button (btn_inc),
        .pulse  (p_inc)
    );

    always_comb begin
        h_next = H_W'(bcd_inc(4'(set_h_msd), set_h_lsd, HOUR_MAX));
        m_next = M_W'(bcd_inc(4'(set_m_msd), set_m_lsd, MINSEC_MAX));
        s_next = S_W'(bcd_inc(4'(set_s_msd), set_s_lsd, MINSEC_MAX));
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= RUN;
            run       <= 1'b1;
            load      <= 1'b0;
            set_h_msd <= '0;
            set_h_lsd <= '0;
            set_m_msd <= '0;
            set_m_lsd <= '0;
            set_s_msd <= '0;
            set_s_lsd <= '0;
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else begin
            load <= 1'b0;

            // Entering any SET state restarts the blink so the field is visible first.
            if (p_mode && state != SET_S) begin
                blink_cnt <= '0;
                phase     <= 1'b0;
            end else if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end

            // p_mode is tested first in every state, so a coincident p_inc is dropped.
            case (state)
                RUN: begin
                    if (p_mode) begin
                        state     <= SET_H;
                        run       <= 1'b0;
                        set_h_msd <= cur_h_msd;
                        set_h_lsd <= cur_h_lsd;
                        set_m_msd <= cur_m_msd;
                        set_m_lsd <= cur_m_lsd;
                        set_s_msd <= cur_s_msd;
                        set_s_lsd <= cur_s_lsd;
                    end
                end
                SET_H: begin
                    if (p_mode) begin
                        state <= SET_M;
                    end else if (p_inc) begin
                        set_h_msd <= h_next[H_LSD_W +: H_MSD_W];
                        set_h_lsd <= h_next[H_LSD_W-1:0];
                    end
                end
                SET_M: begin
                    if (p_mode) begin
                        state <= SET_S;
                    end else if (p_inc) begin
                        set_m_msd <= m_next[M_LSD_W +: M_MSD_W];
                        set_m_lsd <= m_next[M_LSD_W-1:0];
                    end
                end
                SET_S: begin
                    if (p_mode) begin
                        state <= RUN;
                        run   <= 1'b1;
                        load  <= 1'b1;
                    end else if (p_inc) begin
                        set_s_msd <= s_next[S_LSD_W +: S_MSD_W];
                        set_s_lsd <= s_next[S_LSD_W-1:0];
                    end
                end
                default: begin
                    state <= RUN;
                    run   <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        blank = '0;
        case (state)
            SET_H: begin
                blank[BLANK_H_MSD] = phase;
                blank[BLANK_H_LSD] = phase;
            end
            SET_M: begin
                blank[BLANK_M_MSD] = phase;
                blank[BLANK_M_LSD] = phase;
            end
            SET_S: begin
                blank[BLANK_S_MSD] = phase;
                blank[BLANK_S_LSD] = phase;
            end
            default: blank = '0;
        endcase
    end

endmodule
